// File: rtl/gb_mem_pkg.sv
// Shared memory-map constants and DMA types for the Game Boy core.
package gb_mem_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned OAM_BYTES = 160;

  localparam logic [ADDR_W-1:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [BYTE_W-1:0] ECHO_LIMIT   = 8'hDF;
  localparam logic [BYTE_W-1:0] OAM_LAST     = BYTE_W'(OAM_BYTES - 1);
  localparam logic [BYTE_W-1:0] ECHO_OFFSET  = 8'h20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dma_state_t;

  // Pages above DFxx alias work RAM (echo region), so fold them back down.
  function automatic logic [BYTE_W-1:0] echo_remap(input logic [BYTE_W-1:0] hi);
    return (hi > ECHO_LIMIT) ? hi - ECHO_OFFSET : hi;
  endfunction

endpackage

// File: rtl/dma_pacer.sv
// Mod-N byte pacer for the OAM DMA. Optional macro: OAM_DMA_INSTANT_EN
// (defined -> tick every clock, N ignored).
// o_tick reports that the count for the coming cycle is 0, so the caller can
// register a strobe that lands exactly on that cycle.
module dma_pacer #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Next count: wrap at N-1, synchronous clear restarts the phase at 0.
  always_comb begin
    w_cnt_nxt = r_cnt + CNT_W'(1);
    if (i_clr || (r_cnt == CNT_W'(N - 1))) begin
      w_cnt_nxt = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

`ifdef OAM_DMA_INSTANT_EN
  assign o_tick = 1'b1;
`else
  assign o_tick = (w_cnt_nxt == '0);
`endif

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: copies 160 bytes from {FF46, 00} into OAM at bus pace.
// Optional macro: OAM_DMA_INSTANT_EN (one byte per clock, no pacing).
module oam_dma_ctrl
  import gb_mem_pkg::*;
#(
  parameter int unsigned CYCLES_PER_BYTE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_we,
  input  logic [BYTE_W-1:0] reg_wdata,
  output logic [BYTE_W-1:0] reg_rdata,
  output logic              src_re,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [BYTE_W-1:0] src_rd_data,
  output logic              oam_we,
  output logic [BYTE_W-1:0] oam_addr,
  output logic [BYTE_W-1:0] oam_wdata,
  output logic              busy
);

  dma_state_t        r_state, w_state_nxt;
  logic [BYTE_W-1:0] r_src_hi, w_src_hi_nxt;
  logic [BYTE_W-1:0] r_idx, w_idx_nxt;
  logic [BYTE_W-1:0] r_wr_idx, w_wr_idx_nxt;
  logic              r_src_re, w_src_re_nxt;
  logic [ADDR_W-1:0] r_src_addr, w_src_addr_nxt;
  logic              r_oam_we;
  logic [BYTE_W-1:0] r_oam_addr;
  logic              r_busy;

  logic              w_tick;
  logic              w_rd_go;
  logic [BYTE_W-1:0] w_rd_idx;
  logic [BYTE_W-1:0] w_rd_hi;

  dma_pacer #(
    .N (CYCLES_PER_BYTE)
  ) u_pacer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (reg_we),
    .o_tick (w_tick)
  );

  // Next state and next read; outputs are registered from these values.
  always_comb begin
    w_state_nxt    = r_state;
    w_src_hi_nxt   = r_src_hi;
    w_idx_nxt      = r_idx;
    w_wr_idx_nxt   = r_wr_idx;
    w_src_re_nxt   = 1'b0;
    w_src_addr_nxt = r_src_addr;
    w_rd_go        = 1'b0;
    w_rd_idx       = r_idx;
    w_rd_hi        = echo_remap(r_src_hi);

    if (reg_we) begin
      // Any write (re)starts from byte 0 with the new page.
      w_state_nxt  = RUN;
      w_src_hi_nxt = reg_wdata;
      w_rd_go      = 1'b1;
      w_rd_idx     = '0;
      w_rd_hi      = echo_remap(reg_wdata);
    end else begin
      case (r_state)
        RUN: begin
          if (r_src_re && (r_wr_idx == OAM_LAST)) begin
            w_state_nxt = DRAIN;
          end else if (w_tick) begin
            w_rd_go = 1'b1;
          end
        end
        DRAIN:   w_state_nxt = IDLE;
        default: w_state_nxt = r_state;
      endcase
    end

    if (w_rd_go) begin
      w_src_re_nxt   = 1'b1;
      w_src_addr_nxt = {w_rd_hi, w_rd_idx};
      w_wr_idx_nxt   = w_rd_idx;
      w_idx_nxt      = (w_rd_idx == OAM_LAST) ? w_rd_idx : w_rd_idx + BYTE_W'(1);
    end
  end

  // State, read strobe and the one-deep write pipeline behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_src_hi   <= '0;
      r_idx      <= '0;
      r_wr_idx   <= '0;
      r_src_re   <= 1'b0;
      r_src_addr <= '0;
      r_oam_we   <= 1'b0;
      r_oam_addr <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_src_hi   <= w_src_hi_nxt;
      r_idx      <= w_idx_nxt;
      r_wr_idx   <= w_wr_idx_nxt;
      r_src_re   <= w_src_re_nxt;
      r_src_addr <= w_src_addr_nxt;
      r_oam_we   <= r_src_re;
      if (r_src_re) begin
        r_oam_addr <= r_wr_idx;
      end
      r_busy     <= (w_state_nxt != IDLE);
    end
  end

  assign reg_rdata = r_src_hi;
  assign src_re    = r_src_re;
  assign src_addr  = r_src_addr;
  assign oam_we    = r_oam_we;
  assign oam_addr  = r_oam_addr;
  // Source BRAM data lands in the write cycle; gate so idle output stays 0.
  assign oam_wdata = r_oam_we ? src_rd_data : '0;
  assign busy      = r_busy;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl (paced, or instant with OAM_DMA_INSTANT_EN).
module tb_oam_dma_ctrl;

`ifdef OAM_DMA_INSTANT_EN
  localparam int CPB = 1;
`else
  localparam int CPB = 4;
`endif
  localparam int NBYTES   = 160;
  localparam int BUSY_LOW = 159 * CPB + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_we;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        src_re;
  logic [15:0] src_addr;
  logic [7:0]  src_rd_data;
  logic        oam_we;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] sb_q[$];
  logic [7:0]  mem_q = 8'h00;

  typedef struct packed {
    logic [7:0] wdata;
    logic [7:0] exp_hi;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  // Source memory model: one-cycle read latency, data = low ^ high address byte.
  always @(posedge clk) begin
    if (src_re) mem_q <= src_addr[7:0] ^ src_addr[15:8];
  end
  assign src_rd_data = mem_q;

  oam_dma_ctrl #(.CYCLES_PER_BYTE(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .reg_we      (reg_we),
    .reg_wdata   (reg_wdata),
    .reg_rdata   (reg_rdata),
    .src_re      (src_re),
    .src_addr    (src_addr),
    .src_rd_data (src_rd_data),
    .oam_we      (oam_we),
    .oam_addr    (oam_addr),
    .oam_wdata   (oam_wdata),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_expected(input logic [7:0] hi);
    for (int k = 0; k < NBYTES; k++) sb_q.push_back({8'(k), 8'(k) ^ hi});
  endtask

  task automatic start_write(input logic [7:0] v);
    @(negedge clk);
    reg_we    = 1'b1;
    reg_wdata = v;
    @(posedge clk);
    #1 reg_we = 1'b0;
  endtask

  // Observe cycles 1..ncyc after a start; writes are popped from the scoreboard.
  task automatic watch(input int ncyc, input logic [7:0] hi, input logic prev_init,
                       output int rd_cnt, output int busy_low, output int sched_bad,
                       output int busy_gap, output int extra_wr);
    logic prev_re;
    logic [15:0] e;
    prev_re   = prev_init;
    rd_cnt    = 0;
    busy_low  = -1;
    sched_bad = 0;
    busy_gap  = 0;
    extra_wr  = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (oam_we !== prev_re) sched_bad++;
      if (oam_we === 1'b1) begin
        if (sb_q.size() == 0) extra_wr++;
        else begin
          e = sb_q.pop_front();
          check("oam_write", {16'h0, oam_addr, oam_wdata}, {16'h0, e});
        end
      end
      if (src_re === 1'b1) begin
        if (c != 1 + rd_cnt * CPB || src_addr !== {hi, 8'(rd_cnt)}) sched_bad++;
        rd_cnt++;
      end
      if (busy !== 1'b1 && busy_low < 0) busy_low = c;
      if (busy === 1'b1 && busy_low >= 0) busy_gap++;
      prev_re = src_re;
    end
  endtask

  initial begin
    int rd, bl, sb, gap, ex, quiet, exp_rd, exp_bl;
    logic trail;

    vecs[0] = '{wdata: 8'hC1, exp_hi: 8'hC1};
    vecs[1] = '{wdata: 8'hE3, exp_hi: 8'hC3};
    vecs[2] = '{wdata: 8'hFF, exp_hi: 8'hDF};
    vecs[3] = '{wdata: 8'hDF, exp_hi: 8'hDF};
    vecs[4] = '{wdata: 8'hE0, exp_hi: 8'hC0};
    vecs[5] = '{wdata: 8'h00, exp_hi: 8'h00};

    rst = 1'b1; reg_we = 1'b0; reg_wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values, then a quiet idle stretch.
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_src_re", 32'(src_re), 0);
    check("rst_oam_we", 32'(oam_we), 0);
    check("rst_reg_rdata", 32'(reg_rdata), 0);
    check("rst_src_addr", 32'(src_addr), 0);
    check("rst_oam_addr", 32'(oam_addr), 0);
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (|{busy, src_re, oam_we, src_addr, oam_addr, oam_wdata, reg_rdata}) quiet++;
    end
    check("idle_quiet", 32'(quiet), 0);

    // Full transfers from several pages, including the echo region.
    for (int v = 0; v < 6; v++) begin
      sb_q.delete();
      push_expected(vecs[v].exp_hi);
      start_write(vecs[v].wdata);
      watch(BUSY_LOW + 8, vecs[v].exp_hi, 1'b0, rd, bl, sb, gap, ex);
      check($sformatf("reads_%0d", v), 32'(rd), NBYTES);
      check($sformatf("schedule_%0d", v), 32'(sb), 0);
      check($sformatf("busy_fall_%0d", v), 32'(bl), 32'(BUSY_LOW));
      check($sformatf("busy_gap_%0d", v), 32'(gap), 0);
      check($sformatf("extra_wr_%0d", v), 32'(ex), 0);
      check($sformatf("sb_left_%0d", v), 32'(sb_q.size()), 0);
      check($sformatf("reg_rdata_%0d", v), 32'(reg_rdata), 32'(vecs[v].wdata));
    end

    // Restart mid-transfer: C0, then D0 written in cycle 201.
    sb_q.delete();
    push_expected(8'hC0);
    start_write(8'hC0);
    watch(200, 8'hC0, 1'b0, rd, bl, sb, gap, ex);
    exp_rd = (199 / CPB + 1 > NBYTES) ? NBYTES : 199 / CPB + 1;
    exp_bl = (BUSY_LOW <= 200) ? BUSY_LOW : -1;
    check("rs_first_reads", 32'(rd), 32'(exp_rd));
    check("rs_first_sched", 32'(sb), 0);
    check("rs_first_busy", 32'(bl), 32'(exp_bl));
    trail = (200 % CPB == 0) && (200 / CPB <= 159);
    sb_q.delete();
    if (trail) sb_q.push_back({8'(200 / CPB), 8'(200 / CPB) ^ 8'hC0});
    push_expected(8'hD0);
    start_write(8'hD0);
    watch(BUSY_LOW + 8, 8'hD0, trail, rd, bl, sb, gap, ex);
    check("rs_reads", 32'(rd), NBYTES);
    check("rs_sched", 32'(sb), 0);
    check("rs_busy_fall", 32'(bl), 32'(BUSY_LOW));
    check("rs_busy_gap", 32'(gap), 0);
    check("rs_extra_wr", 32'(ex), 0);
    check("rs_sb_left", 32'(sb_q.size()), 0);

    // Reset during a transfer: sampled at edge 300, nothing afterwards.
    sb_q.delete();
    push_expected(8'hC5);
    start_write(8'hC5);
    watch(299, 8'hC5, 1'b0, rd, bl, sb, gap, ex);
    check("rm_sched", 32'(sb), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    quiet = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (oam_we !== 1'b0 || src_re !== 1'b0 || busy !== 1'b0) quiet++;
    end
    check("rm_quiet", 32'(quiet), 0);
    check("rm_reg_rdata", 32'(reg_rdata), 0);
    check("rm_oam_wdata", 32'(oam_wdata), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
